// File: rtl/srlzr_pkg.sv
// Shared serializer/deserializer definitions: default link parameters and FSM encodings.
// No logic; constants and a counter-width helper only.
// Backpressure: not applicable.
package srlzr_pkg;

    // Link defaults shared with the serializer side
    localparam int         SRLZR_DATA_WIDTH  = 4;
    localparam logic [3:0] SRLZR_SYNC_WORD   = 4'b1101;
    localparam int         SRLZR_FRAME_WORDS = 4;
    localparam int         SRLZR_MISS_LIMIT  = 2;

    // Deserializer FSM encodings
    localparam logic [1:0] ST_HUNT  = 2'd0;
    localparam logic [1:0] ST_DATA  = 2'd1;
    localparam logic [1:0] ST_CHECK = 2'd2;

    typedef enum logic [1:0] {
        HUNT  = ST_HUNT,
        DATA  = ST_DATA,
        CHECK = ST_CHECK
    } state_e;

    // Width of a counter holding values 0..n-1, never narrower than one bit
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sipo_shreg.sv
// Serial-in parallel-out shift register, MSB first (oldest bit ends up at the top).
// Latency: one clk per bit; q reflects a sampled bit the cycle after the edge.
// Backpressure: none; en=0 freezes the contents.
module sipo_shreg #(
    parameter int DATA_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  din,
    output logic [DATA_WIDTH-1:0] q
);

    logic [DATA_WIDTH-1:0] shreg_q;

    // Shift one bit in on every enabled edge; reset wins over enable
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shreg_q <= '0;
        end else if (en) begin
            shreg_q <= {shreg_q[DATA_WIDTH-2:0], din};
        end
    end

    assign q = shreg_q;

endmodule

// File: rtl/srlzr_deserializer.sv
// Serial deserializer: hunts for SYNC_WORD, emits FRAME_WORDS payload words per frame, flywheels over bad syncs.
// Latency: data_out/data_valid update on the edge sampling a word's last bit (visible one cycle later).
// Backpressure: none on output; din_en=0 stalls all state, only the one-cycle pulses clear.
module srlzr_deserializer
    import srlzr_pkg::*;
#(
    parameter int                    DATA_WIDTH  = SRLZR_DATA_WIDTH,
    parameter logic [DATA_WIDTH-1:0] SYNC_WORD   = SRLZR_SYNC_WORD,
    parameter int                    FRAME_WORDS = SRLZR_FRAME_WORDS,
    parameter int                    MISS_LIMIT  = SRLZR_MISS_LIMIT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  din,
    input  logic                  din_en,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  locked,
    output logic                  sync_err
);

    localparam int BCW = cnt_width(DATA_WIDTH);
    localparam int WCW = cnt_width(FRAME_WORDS);
    localparam int MCW = cnt_width(MISS_LIMIT + 1);

    localparam logic [BCW-1:0] BIT_LAST  = BCW'(DATA_WIDTH - 1);
    localparam logic [WCW-1:0] WORD_LAST = WCW'(FRAME_WORDS - 1);
    localparam logic [MCW-1:0] MISS_MAX  = MCW'(MISS_LIMIT);

    state_e                state_q;
    logic [BCW-1:0]        bit_cnt_q;
    logic [WCW-1:0]        word_cnt_q;
    logic [MCW-1:0]        miss_cnt_q;
    logic [DATA_WIDTH-1:0] data_out_q;
    logic                  data_valid_q;
    logic                  locked_q;
    logic                  sync_err_q;

    logic [DATA_WIDTH-1:0] shreg_q;
    logic [DATA_WIDTH-1:0] word_d;
    logic [MCW-1:0]        miss_cnt_d;
    logic                  shreg_unused;

    sipo_shreg #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_shreg (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (din_en),
        .din   (din),
        .q     (shreg_q)
    );

    // Word as it will stand after the current bit is shifted in; the oldest
    // register bit falls off the end and is never looked at.
    assign word_d       = {shreg_q[DATA_WIDTH-2:0], din};
    assign shreg_unused = shreg_q[DATA_WIDTH-1];
    // Only evaluated in CHECK while locked, where miss_cnt_q < MISS_LIMIT
    assign miss_cnt_d   = miss_cnt_q + MCW'(1);

    // Alignment FSM with counters and registered outputs; pulses self-clear
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= HUNT;
            bit_cnt_q    <= '0;
            word_cnt_q   <= '0;
            miss_cnt_q   <= '0;
            data_out_q   <= '0;
            data_valid_q <= 1'b0;
            locked_q     <= 1'b0;
            sync_err_q   <= 1'b0;
        end else begin
            data_valid_q <= 1'b0;
            sync_err_q   <= 1'b0;
            if (din_en) begin
                unique case (state_q)
                    HUNT: begin
                        // Sliding compare on every bit; a payload pattern may
                        // false-lock, and CHECK misses are what recover it.
                        if (word_d == SYNC_WORD) begin
                            state_q    <= DATA;
                            locked_q   <= 1'b1;
                            bit_cnt_q  <= '0;
                            word_cnt_q <= '0;
                            miss_cnt_q <= '0;
                        end
                    end
                    DATA: begin
                        if (bit_cnt_q == BIT_LAST) begin
                            bit_cnt_q    <= '0;
                            data_out_q   <= word_d;
                            data_valid_q <= 1'b1;
                            if (word_cnt_q == WORD_LAST) begin
                                word_cnt_q <= '0;
                                state_q    <= CHECK;
                            end else begin
                                word_cnt_q <= word_cnt_q + WCW'(1);
                            end
                        end else begin
                            bit_cnt_q <= bit_cnt_q + BCW'(1);
                        end
                    end
                    CHECK: begin
                        // Sync slot: consumed here, never presented as payload
                        if (bit_cnt_q == BIT_LAST) begin
                            bit_cnt_q <= '0;
                            if (word_d == SYNC_WORD) begin
                                miss_cnt_q <= '0;
                                state_q    <= DATA;
                            end else begin
                                sync_err_q <= 1'b1;
                                miss_cnt_q <= miss_cnt_d;
                                if (miss_cnt_d == MISS_MAX) begin
                                    state_q  <= HUNT;
                                    locked_q <= 1'b0;
                                end else begin
                                    state_q <= DATA;
                                end
                            end
                        end else begin
                            bit_cnt_q <= bit_cnt_q + BCW'(1);
                        end
                    end
                    default: begin
                        state_q  <= HUNT;
                        locked_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign data_out   = data_out_q;
    assign data_valid = data_valid_q;
    assign locked     = locked_q;
    assign sync_err   = sync_err_q;

endmodule

// File: tb/tb_srlzr_deserializer.sv
// Directed bench for srlzr_deserializer with a 2-word frame and a 2-miss lock limit.
// Inputs change on the falling edge; outputs are sampled 1 time unit after the rising edge.
// Expected values are hand-computed constants per step.
module tb_srlzr_deserializer;

    logic       clk;
    logic       rst_n;
    logic       din;
    logic       din_en;
    logic [3:0] data_out;
    logic       data_valid;
    logic       locked;
    logic       sync_err;

    int n_assert;
    int n_fail;

    logic dv_seen;
    logic se_seen;
    logic lk_early;

    srlzr_deserializer #(
        .DATA_WIDTH  (4),
        .SYNC_WORD   (4'b1101),
        .FRAME_WORDS (2),
        .MISS_LIMIT  (2)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .din_en     (din_en),
        .data_out   (data_out),
        .data_valid (data_valid),
        .locked     (locked),
        .sync_err   (sync_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        @(negedge clk);
        din    = b;
        din_en = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        din    = 1'($urandom);
        din_en = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic reset_cycle();
        @(negedge clk);
        rst_n  = 1'b0;
        din    = 1'($urandom);
        din_en = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic release_reset();
        @(negedge clk);
        rst_n  = 1'b1;
        din_en = 1'b0;
    endtask

    // Sends one word MSB first; records pulses seen on the first three bits
    // and the lock state after the third bit.
    task automatic send_word(input logic [3:0] w);
        dv_seen  = 1'b0;
        se_seen  = 1'b0;
        lk_early = 1'b0;
        for (int i = 3; i >= 0; i--) begin
            send_bit(w[i]);
            if (i != 0) begin
                dv_seen = dv_seen | data_valid;
                se_seen = se_seen | sync_err;
            end
            if (i == 1) lk_early = locked;
        end
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        din      = 1'b0;
        din_en   = 1'b0;

        // Reset with random serial data
        reset_cycle();
        reset_cycle();
        chk("rst_data_out", 8'(data_out), 8'h0);
        chk("rst_data_valid", 8'(data_valid), 8'h0);
        chk("rst_locked", 8'(locked), 8'h0);
        chk("rst_sync_err", 8'(sync_err), 8'h0);
        release_reset();

        // Lock and payload: 1101 0011 1010 1101 0110
        send_word(4'hD);
        chk("lock_before_bit4", 8'(lk_early), 8'h0);
        chk("lock_after_bit4", 8'(locked), 8'h1);
        chk("lock_no_dv", 8'(data_valid), 8'h0);
        send_word(4'h3);
        chk("w3_dv", 8'(data_valid), 8'h1);
        chk("w3_data", 8'(data_out), 8'h3);
        send_word(4'hA);
        chk("wA_prev_pulse_1cyc", 8'(dv_seen), 8'h0);
        chk("wA_dv", 8'(data_valid), 8'h1);
        chk("wA_data", 8'(data_out), 8'hA);
        send_word(4'hD);
        chk("sync_no_dv_early", 8'(dv_seen), 8'h0);
        chk("sync_no_dv", 8'(data_valid), 8'h0);
        chk("sync_data_hold", 8'(data_out), 8'hA);
        chk("sync_no_err", 8'(sync_err | se_seen), 8'h0);
        send_word(4'h6);
        chk("w6_dv", 8'(data_valid), 8'h1);
        chk("w6_data", 8'(data_out), 8'h6);

        // Flywheel: one bad sync tolerated
        send_word(4'h5);
        chk("w5_data", 8'(data_out), 8'h5);
        send_word(4'h0);
        chk("bad1_sync_err", 8'(sync_err), 8'h1);
        chk("bad1_locked", 8'(locked), 8'h1);
        chk("bad1_no_dv", 8'(data_valid), 8'h0);
        send_word(4'h7);
        chk("fly_err_1cyc", 8'(se_seen), 8'h0);
        chk("fly_w7_dv", 8'(data_valid), 8'h1);
        chk("fly_w7_data", 8'(data_out), 8'h7);
        send_word(4'h8);
        chk("fly_w8_data", 8'(data_out), 8'h8);
        send_word(4'hD);
        chk("good_sync_no_err", 8'(sync_err), 8'h0);

        // Two consecutive bad syncs drop lock on the second
        send_word(4'h1);
        send_word(4'h2);
        chk("w2_data", 8'(data_out), 8'h2);
        send_word(4'h0);
        chk("bad2a_sync_err", 8'(sync_err), 8'h1);
        chk("bad2a_locked", 8'(locked), 8'h1);
        send_word(4'h4);
        send_word(4'hE);
        chk("wE_data", 8'(data_out), 8'hE);
        send_word(4'h0);
        chk("bad2b_sync_err", 8'(sync_err), 8'h1);
        chk("bad2b_unlocked", 8'(locked), 8'h0);
        send_word(4'hF);
        chk("hunt_no_dv", 8'(dv_seen | data_valid), 8'h0);
        chk("hunt_no_err", 8'(se_seen | sync_err), 8'h0);
        chk("hunt_locked", 8'(locked), 8'h0);
        chk("hunt_data_hold", 8'(data_out), 8'hE);

        // Misaligned hunt: 01 then 1101 0101
        reset_cycle();
        release_reset();
        send_bit(1'b0);
        send_bit(1'b1);
        chk("mis_not_locked", 8'(locked), 8'h0);
        send_word(4'hD);
        chk("mis_lock_before_bit6", 8'(lk_early), 8'h0);
        chk("mis_lock_after_bit6", 8'(locked), 8'h1);
        send_word(4'h5);
        chk("mis_first_dv", 8'(data_valid), 8'h1);
        chk("mis_first_data", 8'(data_out), 8'h5);

        // Gaps: payload 0x9 with three idle cycles between bits 2 and 3
        send_bit(1'b1);
        chk("gap_bit1_no_dv", 8'(data_valid), 8'h0);
        send_bit(1'b0);
        for (int g = 0; g < 3; g++) begin
            idle_cycle();
            chk("gap_idle_no_dv", 8'(data_valid), 8'h0);
            chk("gap_idle_locked", 8'(locked), 8'h1);
        end
        send_bit(1'b0);
        chk("gap_bit3_no_dv", 8'(data_valid), 8'h0);
        send_bit(1'b1);
        chk("gap_dv", 8'(data_valid), 8'h1);
        chk("gap_data", 8'(data_out), 8'h9);
        idle_cycle();
        chk("gap_dv_1cyc", 8'(data_valid), 8'h0);
        send_word(4'hD);
        chk("gap_sync_ok", 8'(sync_err | se_seen), 8'h0);

        // Reset mid-word after two payload bits
        send_bit(1'b1);
        send_bit(1'b1);
        reset_cycle();
        chk("midrst_data_out", 8'(data_out), 8'h0);
        chk("midrst_locked", 8'(locked), 8'h0);
        chk("midrst_dv", 8'(data_valid), 8'h0);
        chk("midrst_err", 8'(sync_err), 8'h0);
        release_reset();
        send_bit(1'b0);
        send_bit(1'b1);
        chk("midrst_partial_discarded", 8'(locked), 8'h0);
        send_word(4'hD);
        chk("relock_before_full", 8'(lk_early), 8'h0);
        chk("relock_full_sync", 8'(locked), 8'h1);
        send_word(4'hC);
        chk("relock_dv", 8'(data_valid), 8'h1);
        chk("relock_data", 8'(data_out), 8'hC);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
